// File: rtl/sap1_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sap1_pkg                                                             |
// | Opcodes, control-word bit indices and T-state encodings for SAP-1.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package sap1_pkg;

    typedef enum logic [3:0] {
        OP_LDA = 4'b0000,
        OP_ADD = 4'b0001,
        OP_SUB = 4'b0010,
        OP_OUT = 4'b1110,
        OP_HLT = 4'b1111
    } opcode_e;

    localparam int CW_CP = 0;
    localparam int CW_EP = 1;
    localparam int CW_LM = 2;
    localparam int CW_CE = 3;
    localparam int CW_LI = 4;
    localparam int CW_EI = 5;
    localparam int CW_LA = 6;
    localparam int CW_EA = 7;
    localparam int CW_SU = 8;
    localparam int CW_EU = 9;
    localparam int CW_LB = 10;
    localparam int CW_LO = 11;
    localparam int CW_W  = 12;

    typedef logic [CW_W-1:0] ctrl_word_t;

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

endpackage
`default_nettype wire

// File: rtl/sap1_ring_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sap1_ring_counter                                                    |
// | One-hot T-state ring with asynchronous clear and a freeze hold.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sap1_ring_counter #(
    parameter int RING_LEN = 6
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                freeze_i,
    output logic [RING_LEN-1:0] ring_o
);

    logic [RING_LEN-1:0] ring_q;
    logic [RING_LEN-1:0] ring_d;

    always_comb begin
        ring_d = ring_q;
        if (!freeze_i) begin
            ring_d = {ring_q[RING_LEN-2:0], ring_q[RING_LEN-1]};
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ring_q <= RING_LEN'(1);
        end else begin
            ring_q <= ring_d;
        end
    end

    assign ring_o = ring_q;

endmodule
`default_nettype wire

// File: rtl/sap1_controller_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sap1_controller_sequencer                                            |
// | T-state sequencing, halt latch and control-word decode for SAP-1.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sap1_controller_sequencer
    import sap1_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int RING_LEN = 6
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [OPCODE_W-1:0] opcode,
    output logic [RING_LEN-1:0] t_state,
    output logic                cp,
    output logic                ep,
    output logic                lm,
    output logic                ce,
    output logic                li,
    output logic                ei,
    output logic                la,
    output logic                ea,
    output logic                su,
    output logic                eu,
    output logic                lb,
    output logic                lo,
    output logic                hlt
);

    logic [RING_LEN-1:0] ring;
    logic                halted_q;
    logic                halted_d;
    ctrl_word_t          cw;

    logic w_is_lda;
    logic w_is_add;
    logic w_is_sub;
    logic w_is_out;
    logic w_is_hlt;

    assign w_is_lda = (opcode == OPCODE_W'(OP_LDA));
    assign w_is_add = (opcode == OPCODE_W'(OP_ADD));
    assign w_is_sub = (opcode == OPCODE_W'(OP_SUB));
    assign w_is_out = (opcode == OPCODE_W'(OP_OUT));
    assign w_is_hlt = (opcode == OPCODE_W'(OP_HLT));

    // Ring holds while halted; its contents are irrelevant until clr reloads T1.
    sap1_ring_counter #(
        .RING_LEN (RING_LEN)
    ) u_ring (
        .clk      (clk),
        .clr      (clr),
        .freeze_i (halted_q),
        .ring_o   (ring)
    );

    assign halted_d = halted_q | ((ring == T4) & w_is_hlt);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    always_comb begin
        cw = '0;
        if (!halted_q) begin
            case (ring)
                T1: begin
                    cw[CW_EP] = 1'b1;
                    cw[CW_LM] = 1'b1;
                end
                T2: cw[CW_CP] = 1'b1;
                T3: begin
                    cw[CW_CE] = 1'b1;
                    cw[CW_LI] = 1'b1;
                end
                T4: begin
                    if (w_is_lda | w_is_add | w_is_sub) begin
                        cw[CW_EI] = 1'b1;
                        cw[CW_LM] = 1'b1;
                    end else if (w_is_out) begin
                        cw[CW_EA] = 1'b1;
                        cw[CW_LO] = 1'b1;
                    end
                end
                T5: begin
                    if (w_is_lda) begin
                        cw[CW_CE] = 1'b1;
                        cw[CW_LA] = 1'b1;
                    end else if (w_is_add | w_is_sub) begin
                        cw[CW_CE] = 1'b1;
                        cw[CW_LB] = 1'b1;
                    end
                end
                T6: begin
                    if (w_is_add | w_is_sub) begin
                        cw[CW_EU] = 1'b1;
                        cw[CW_LA] = 1'b1;
                        cw[CW_SU] = w_is_sub;
                    end
                end
                default: cw = '0;
            endcase
        end
    end

    assign t_state = halted_q ? '0 : ring;
    assign hlt     = halted_q;

    assign cp = cw[CW_CP];
    assign ep = cw[CW_EP];
    assign lm = cw[CW_LM];
    assign ce = cw[CW_CE];
    assign li = cw[CW_LI];
    assign ei = cw[CW_EI];
    assign la = cw[CW_LA];
    assign ea = cw[CW_EA];
    assign su = cw[CW_SU];
    assign eu = cw[CW_EU];
    assign lb = cw[CW_LB];
    assign lo = cw[CW_LO];

endmodule
`default_nettype wire

// File: doc/sap1_controller_sequencer.md
Name: sap1_controller_sequencer

Overview:
- Controller-sequencer for the SAP-1 datapath.
- Runs a 6-state ring counter (T1..T6) and decodes the instruction register opcode nibble.
- Drives the active-high load/enable control word consumed by the 8-bit registers (their LR inputs), PC, MAR, RAM, ALU and output port.
- Sits directly upstream of every 8-bit register: it generates their load strobes.

Parameters:
- OPCODE_W, 4, width of the opcode nibble taken from the IR upper bits.
- RING_LEN, 6, number of T-states per instruction; fixed at 6, any other value is unsupported.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- clr  input  1  asynchronous active-high reset.
- opcode  input  OPCODE_W  IR[7:4]; sampled only in T4..T6.
- t_state  output  6  one-hot ring state (bit0=T1 .. bit5=T6); 6'b000000 when halted.
- cp  output  1  PC increment.
- ep  output  1  PC drives bus.
- lm  output  1  MAR load.
- ce  output  1  RAM drives bus.
- li  output  1  IR load.
- ei  output  1  IR address nibble drives bus.
- la  output  1  accumulator A load.
- ea  output  1  A drives bus.
- su  output  1  ALU subtract select (0=add).
- eu  output  1  ALU result drives bus.
- lb  output  1  B register load.
- lo  output  1  output register load.
- hlt  output  1  halted flag.

Behaviour:
- Reset:
  - clr=1 immediately forces state T1, t_state=6'b000001, halted=0, independent of clk.
  - Control outputs are then the T1 decode: ep=lm=1, all others 0, hlt=0.
- Sequencing:
  - Each posedge advances T1->T2->...->T6->T1.
  - No early termination: unused states assert no controls.
- Control outputs are combinational from the current T-state and opcode. Each target register loads at the posedge ending that T-state, so there is zero added latency.
- Fetch (all opcodes):
  - T1: ep, lm.
  - T2: cp.
  - T3: ce, li.
- Opcode is ignored in T1..T3; the IR holds the new value from the end of T3.
- Execute:
  - LDA 4'b0000: T4 ei,lm; T5 ce,la; T6 none.
  - ADD 4'b0001: T4 ei,lm; T5 ce,lb; T6 eu,la (su=0).
  - SUB 4'b0010: T4 ei,lm; T5 ce,lb; T6 eu,la,su.
  - OUT 4'b1110: T4 ea,lo; T5 none; T6 none.
  - HLT 4'b1111: T4 none. At the posedge ending T4, halted is set, the ring freezes, t_state=0, all controls 0, hlt=1. Only clr exits.
  - Any other opcode: NOP (T4..T6 assert nothing; sequencing continues).
- Invariants:
  - At most one of ep, ce, ei, ea, eu is high in any cycle (bus ownership).
  - su is never high without eu.
  - Exactly one bit of t_state is high when not halted.
- Reset mid-instruction: clr aborts immediately. The next instruction fetch restarts at T1, and no partial execute completes after clr.
- Opcode change outside T4..T6 has no effect. Opcode change mid-execute takes effect combinationally; this is legal but not expected, since the IR is stable.

Decomposition:
- Shared package sap1_pkg holds:
  - opcode constants OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT;
  - control-word bit indices (CW_CP .. CW_LO);
  - T-state one-hot constants T1..T6.
- One sub-module, sap1_ring_counter: 6-bit one-hot ring with async clr and a freeze input driven by halted.
- The top level holds the halt flag and the control decode.

Test Plan:
- Reset: assert clr mid-cycle -> t_state=6'b000001 at once, ep=lm=1, hlt=0. Release clr, apply 3 clocks -> t_state walks 000010, 000100, 001000 with cp (T2) and ce,li (T3) asserted.
- LDA: opcode=4'h0 through a full cycle -> T4 ei,lm; T5 ce,la; T6 all controls 0; returns to T1 after 6 clocks.
- ADD then SUB: opcode=4'h1 -> T6 eu=1, la=1, su=0. Opcode=4'h2 -> T6 eu=1, la=1, su=1. Both have T5 ce=lb=1.
- OUT and NOP: opcode=4'hE -> T4 ea=lo=1 only. Opcode=4'h5 -> T4..T6 all controls 0, ring continues.
- HLT: opcode=4'hF -> after the posedge ending T4, hlt=1, t_state=0, controls 0 for 20 clocks. Pulse clr -> t_state=000001, hlt=0.
- Random opcodes over 1000 instructions with random async clr pulses -> assertions for bus one-hot, su implies eu, and t_state one-hot never fire.
